multi_pulse_generator: RTL and testbench
========================================

Name: multi_pulse_generator

Overview:
- NUM_CH independent pulse channels with per-channel period, high-time (width) and mode (continuous or one-shot).
- Adds start/stop control, retrigger, one-shot completion flags and glitch-free period/width updates at period boundaries.
- Shared tick enable `ena` acts as a prescaler strobe.
- Feeds PWM, LED-blink and sampling-strobe consumers in the same clock domain.

Parameters:
N, 8, counter/period/width bit width
NUM_CH, 4, number of independent channels

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  global tick enable; counters advance only when 1
start  input  NUM_CH  per-channel start/retrigger strobe
stop  input  NUM_CH  per-channel stop strobe
mode  input  NUM_CH  per-channel mode: 0 = continuous, 1 = one-shot; sampled at start
period  input  NUM_CH*N  channel i at [i*N +: N]; period is P+1 ticks
width  input  NUM_CH*N  channel i at [i*N +: N]; high time in ticks
out  output  NUM_CH  registered pulse outputs
busy  output  NUM_CH  1 while channel is in RUN
done  output  NUM_CH  one-cycle flag when a one-shot completes

Behaviour:
- Reset (rst_n low, asynchronous): every channel goes to IDLE with count=0 and period/width/mode shadows cleared. out, busy and done are all 0.
- Reset asserted mid-run aborts immediately, with no done flag.
- Per-channel FSM states: IDLE, RUN. All outputs are registered.
- IDLE:
  - out=0, busy=0.
  - start[i]=1 → RUN. Latch period_q, width_q and mode_q from the inputs; count<=0; out<=(width!=0).
  - Start is accepted regardless of ena.
- RUN with ena=1:
  - If count==period_q and mode_q=continuous: count<=0. Reload period_q and width_q from the live inputs; mode is not reloaded. out<=(new width!=0).
  - If count==period_q and mode_q=one-shot: → IDLE; out<=0; done<=1 for exactly one cycle.
  - Otherwise: count<=count+1; out<=((count+1) < width_q).
- RUN with ena=0: count and out hold.
- stop[i]=1: → IDLE next edge; out<=0; no done. stop has priority over a simultaneous start.
- start[i]=1 while in RUN: retrigger. Same actions as a start from IDLE.
- Timing summary:
  - out rises on the first edge after start.
  - In continuous mode, out is high for min(width, P+1) ticks of every P+1 ticks.
  - width=0 gives out permanently 0 while the channel still runs and completes.
  - width>=P+1 gives out permanently 1.
  - P=0 with width>=1 gives out=1 continuously in continuous mode.
- Arithmetic:
  - count is N bits unsigned and can never exceed period_q, so there is no wrap-around.
  - The width comparison is unsigned N-bit; (count+1) never overflows because count<period_q.
- Live period/width changes in continuous mode take effect only at the next period boundary.

Decomposition:
- Package pulse_gen_pkg:
  - typedef enum logic {PG_CONTINUOUS, PG_ONE_SHOT} pg_mode_t
  - typedef enum logic {PG_IDLE, PG_RUN} pg_state_t
- Sub-module pulse_channel: one channel's FSM, counter and shadows, parametrised by N.
- multi_pulse_generator instantiates NUM_CH copies with a generate loop and slices period and width.

Test Plan:
- Reset mid-run: channel 0 running, assert rst_n low between edges → out, busy and done go 0 immediately. After release the channel stays IDLE until the next start.
- Continuous, ena=1, P=4, W=2, start ch0 → out pattern 1,1,0,0,0 repeating. busy=1 and done never asserts.
- One-shot, P=3, W=1, start ch1 → out 1,0,0,0. done=1 on the cycle after the 4th tick; busy falls on the same cycle.
- Live update: continuous P=4, W=2, change to P=2, W=1 mid-period → current period completes as 1,1,0,0,0, then 1,0,0 repeats.
- ena toggling 1,0,1,0 with P=2, W=1 → each out level lasts 2 cycles. A stop and start asserted together → channel goes IDLE, out=0.
- Retrigger and edge widths:
  - Start ch2 with P=5, W=3; re-assert start at count=3 → out returns to 1 and count restarts at 0.
  - W=0 → out stays 0.
  - W=8, P=5 → out stays 1.
- All channels concurrently with distinct configurations → no cross-channel interference.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types for the multi-channel pulse generator
package pulse_gen_pkg;

  typedef enum logic {PG_CONTINUOUS, PG_ONE_SHOT} pg_mode_t;
  typedef enum logic {PG_IDLE, PG_RUN} pg_state_t;

  // Output level for a given tick position inside the period
  function automatic logic pg_level(input logic [31:0] pos, input logic [31:0] high);
    return pos < high;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - one pulse channel: FSM, tick counter and config shadows
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] period,
  input  logic [N-1:0] width,
  output logic         out,
  output logic         busy,
  output logic         done
);

  pg_state_t    state;
  pg_mode_t     mode_q;
  logic [N-1:0] count;
  logic [N-1:0] period_q;
  logic [N-1:0] width_q;
  logic         out_q;
  logic         done_q;
  logic [N-1:0] count_inc;

  // count never exceeds period_q, so the increment cannot wrap
  assign count_inc = count + 1'b1;

  // Channel FSM: stop beats start, start (re)arms from live inputs, ticks advance the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PG_IDLE;
      mode_q   <= PG_CONTINUOUS;
      count    <= '0;
      period_q <= '0;
      width_q  <= '0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state <= PG_IDLE;
        out_q <= 1'b0;
      end else if (start) begin
        state    <= PG_RUN;
        period_q <= period;
        width_q  <= width;
        mode_q   <= pg_mode_t'(mode);
        count    <= '0;
        out_q    <= (width != '0);
      end else if (state == PG_RUN && ena) begin
        if (count == period_q) begin
          if (mode_q == PG_ONE_SHOT) begin
            state  <= PG_IDLE;
            out_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            // period boundary: the only point where live period/width are picked up
            count    <= '0;
            period_q <= period;
            width_q  <= width;
            out_q    <= (width != '0);
          end
        end else begin
          count <= count_inc;
          out_q <= pg_level(32'(count_inc), 32'(width_q));
        end
      end
    end
  end

  assign out  = out_q;
  assign busy = (state == PG_RUN);
  assign done = done_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// rtl/multi_pulse_generator.sv - NUM_CH independent pulse channels sharing one tick enable
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int N      = 8,
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NUM_CH-1:0]   start,
  input  logic [NUM_CH-1:0]   stop,
  input  logic [NUM_CH-1:0]   mode,
  input  logic [NUM_CH*N-1:0] period,
  input  logic [NUM_CH*N-1:0] width,
  output logic [NUM_CH-1:0]   out,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done
);

  // One channel per slice of the packed period/width buses
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_channel #(.N(N)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .start  (start[i]),
      .stop   (stop[i]),
      .mode   (mode[i]),
      .period (period[i*N +: N]),
      .width  (width[i*N +: N]),
      .out    (out[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// tb/tb_multi_pulse_generator.sv - scoreboard bench for multi_pulse_generator
module tb_multi_pulse_generator;

  localparam int N      = 8;
  localparam int NUM_CH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ena;
  logic [NUM_CH-1:0]   start;
  logic [NUM_CH-1:0]   stop;
  logic [NUM_CH-1:0]   mode;
  logic [NUM_CH*N-1:0] period;
  logic [NUM_CH*N-1:0] width;
  logic [NUM_CH-1:0]   out;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   done;

  always #5 clk = ~clk;

  multi_pulse_generator #(.N(N), .NUM_CH(NUM_CH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .period (period),
    .width  (width),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: tick position k within the current period, plus the period/width in force
  bit act [NUM_CH];
  bit os  [NUM_CH];
  int k   [NUM_CH];
  int pc  [NUM_CH];
  int wc  [NUM_CH];

  typedef struct {
    logic [NUM_CH-1:0] o;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] d;
  } exp_t;

  exp_t sb[$];

  task automatic set_cfg(input int ch, input int p, input int w, input bit m);
    period[ch*N +: N] = N'(p);
    width[ch*N +: N]  = N'(w);
    mode[ch]          = m;
  endtask

  task automatic predict();
    exp_t e;
    e.o = '0; e.b = '0; e.d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (stop[ch]) begin
        act[ch] = 1'b0;
      end else if (start[ch]) begin
        act[ch] = 1'b1;
        k[ch]   = 0;
        pc[ch]  = int'(period[ch*N +: N]);
        wc[ch]  = int'(width[ch*N +: N]);
        os[ch]  = mode[ch];
      end else if (act[ch] && ena) begin
        k[ch]++;
        if (k[ch] > pc[ch]) begin
          if (os[ch]) begin
            act[ch]  = 1'b0;
            e.d[ch]  = 1'b1;
          end else begin
            k[ch]  = 0;
            pc[ch] = int'(period[ch*N +: N]);
            wc[ch] = int'(width[ch*N +: N]);
          end
        end
      end
      if (act[ch]) begin
        e.b[ch] = 1'b1;
        e.o[ch] = (k[ch] < wc[ch]);
      end
    end
    sb.push_back(e);
  endtask

  // One clock: queue the expectation, clock the DUT, compare, release strobes
  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val({tag, " out"},  32'(out),  32'(e.o));
      check_val({tag, " busy"}, 32'(busy), 32'(e.b));
      check_val({tag, " done"}, 32'(done), 32'(e.d));
    end
    start = '0;
    stop  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = '0; stop = '0; mode = '0; period = '0; width = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      act[ch] = 1'b0; os[ch] = 1'b0; k[ch] = 0; pc[ch] = 0; wc[ch] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("reset out",  32'(out),  32'd0);
    check_val("reset busy", 32'(busy), 32'd0);
    check_val("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // continuous P=4 W=2 on ch0: 1,1,0,0,0 repeating
    set_cfg(0, 4, 2, 1'b0); start[0] = 1'b1;
    repeat (12) step("cont");
    stop[0] = 1'b1; step("stop0");

    // one-shot P=3 W=1 on ch1: 1,0,0,0 then done
    set_cfg(1, 3, 1, 1'b1); start[1] = 1'b1;
    repeat (7) step("oneshot");

    // live update mid-period on ch0
    set_cfg(0, 4, 2, 1'b0); start[0] = 1'b1;
    step("live");
    step("live");
    set_cfg(0, 2, 1, 1'b0);
    repeat (10) step("live");
    stop[0] = 1'b1; step("live_stop");

    // ena toggling on ch3, then stop+start together
    set_cfg(3, 2, 1, 1'b0); start[3] = 1'b1;
    step("ena");
    for (int i = 0; i < 12; i++) begin
      ena = i[0];
      step("ena");
    end
    ena = 1'b1;
    stop[3] = 1'b1; start[3] = 1'b1;
    step("stopstart");
    step("stopstart");

    // retrigger at count=3 on ch2
    set_cfg(2, 5, 3, 1'b0); start[2] = 1'b1;
    step("retrig");
    repeat (3) step("retrig");
    start[2] = 1'b1;
    repeat (5) step("retrig");

    // width edges and P=0
    set_cfg(2, 5, 0, 1'b0); start[2] = 1'b1;
    repeat (8) step("w0");
    set_cfg(2, 5, 8, 1'b0); start[2] = 1'b1;
    repeat (8) step("wfull");
    set_cfg(2, 0, 1, 1'b0); start[2] = 1'b1;
    repeat (4) step("p0");
    stop[2] = 1'b1; step("p0_stop");

    // all channels concurrently
    set_cfg(0, 3, 2, 1'b0);
    set_cfg(1, 2, 1, 1'b1);
    set_cfg(2, 6, 4, 1'b0);
    set_cfg(3, 1, 1, 1'b0);
    start = 4'hf;
    repeat (16) step("multi");

    // asynchronous reset between edges while channels run
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst out",  32'(out),  32'd0);
    check_val("async_rst busy", 32'(busy), 32'd0);
    check_val("async_rst done", 32'(done), 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) act[ch] = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) step("post_rst");
    set_cfg(0, 1, 1, 1'b0); start[0] = 1'b1;
    repeat (4) step("post_rst_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
